// File: rtl/banco_registros.sv
// -----------------------------------------------------------------------------
// banco_registros
// Architectural register file: 2**ADDR_W registers of DATA_W bits, two
// combinational read ports for decode and one synchronous write port from
// write-back. Register 0 always reads as zero. A write-through bypass lets a
// read in the write cycle see the incoming write data.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; clears every register
//   we       in   write enable from write-back control
//   waddr    in   destination register (from the jump/link selector)
//   wdata    in   write-back data
//   raddr_a  in   read address, port A (rs)
//   raddr_b  in   read address, port B (rt)
//   rdata_a  out  read data, port A (combinational)
//   rdata_b  out  read data, port B (combinational)
// -----------------------------------------------------------------------------
module banco_registros #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_wr_en;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;

    // A write is effective only outside reset and never to register 0.
    assign w_wr_en = !reset && we && (waddr != '0);

    // Storage; register 0 is cleared by reset and never written afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Port A: zero for r0, bypass on a same-cycle write, else stored value.
    always_comb begin
        w_rdata_a = '0;
        if (raddr_a != '0) begin
            if (w_wr_en && (waddr == raddr_a)) begin
                w_rdata_a = wdata;
            end else begin
                w_rdata_a = r_regs[raddr_a];
            end
        end
    end

    // Port B: same rules as port A, evaluated independently.
    always_comb begin
        w_rdata_b = '0;
        if (raddr_b != '0) begin
            if (w_wr_en && (waddr == raddr_b)) begin
                w_rdata_b = wdata;
            end else begin
                w_rdata_b = r_regs[raddr_b];
            end
        end
    end

    assign rdata_a = w_rdata_a;
    assign rdata_b = w_rdata_b;

endmodule

// File: tb/tb_banco_registros.sv
// -----------------------------------------------------------------------------
// tb_banco_registros
// Directed bench for banco_registros: reset clear, r0 hardwiring, link write
// with bypass, dual/same-address reads, reset-vs-write collision and
// back-to-back writes. Inputs change 1 time unit after the rising edge and
// outputs are checked 1 unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_banco_registros;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;

    int checks = 0;
    int errors = 0;

    banco_registros #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        we      = 1'b0;
        waddr   = 5'd0;
        wdata   = 32'h0;
        raddr_a = 5'd0;
        raddr_b = 5'd5;
        tick();
        reset = 1'b0;
        #1;
        check("reset_r0_a", rdata_a, 32'h0);
        check("reset_r5_b", rdata_b, 32'h0);

        // Reset clear: write r5, then reset, then sweep
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0; raddr_a = 5'd5;
        #1;
        check("r5_stored", rdata_a, 32'hDEADBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("r5_after_reset", rdata_a, 32'h0);
        for (int i = 1; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(32 - i);
            #1;
            check("sweep_a", rdata_a, 32'h0);
            check("sweep_b", rdata_b, 32'h0);
        end

        // r0 hardwired
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        raddr_a = 5'd0; raddr_b = 5'd0;
        #1;
        check("r0_write_cycle", rdata_a, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0_after_write", rdata_a, 32'h0);

        // Link write to r31: bypass then storage
        we = 1'b1; waddr = 5'd31; wdata = 32'h00400008;
        raddr_a = 5'd31; raddr_b = 5'd30;
        #1;
        check("link_bypass_a", rdata_a, 32'h00400008);
        check("link_other_b", rdata_b, 32'h0);
        tick();
        we = 1'b0; raddr_b = 5'd31;
        #1;
        check("link_stored_b", rdata_b, 32'h00400008);

        // Dual-port and same-address reads
        we = 1'b1; waddr = 5'd3; wdata = 32'h11111111;
        tick();
        waddr = 5'd4; wdata = 32'h22222222;
        tick();
        we = 1'b0; raddr_a = 5'd3; raddr_b = 5'd4;
        #1;
        check("dual_a_r3", rdata_a, 32'h11111111);
        check("dual_b_r4", rdata_b, 32'h22222222);
        raddr_a = 5'd4;
        #1;
        check("same_a_r4", rdata_a, 32'h22222222);
        check("same_b_r4", rdata_b, 32'h22222222);
        we = 1'b1; waddr = 5'd4; wdata = 32'h33333333;
        #1;
        check("same_bypass_a", rdata_a, 32'h33333333);
        check("same_bypass_b", rdata_b, 32'h33333333);
        tick();
        we = 1'b0;
        #1;
        check("same_stored_b", rdata_b, 32'h33333333);

        // Reset versus write collision
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        tick();
        reset = 1'b1; waddr = 5'd7; wdata = 32'hCAFEF00D;
        raddr_a = 5'd7; raddr_b = 5'd3;
        #1;
        check("collision_no_bypass", rdata_a, 32'h12345678);
        tick();
        reset = 1'b0; we = 1'b0;
        #1;
        check("collision_r7_cleared", rdata_a, 32'h0);
        check("collision_r3_cleared", rdata_b, 32'h0);

        // Back-to-back writes to r9
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000000A; raddr_a = 5'd9;
        #1;
        check("b2b_first_bypass", rdata_a, 32'h0000000A);
        tick();
        wdata = 32'h0000000B;
        #1;
        check("b2b_second_bypass", rdata_a, 32'h0000000B);
        tick();
        we = 1'b0;
        #1;
        check("b2b_stored", rdata_a, 32'h0000000B);

        // we=0 neither bypasses nor writes
        waddr = 5'd9; wdata = 32'hFFFF0000;
        #1;
        check("we0_no_bypass", rdata_a, 32'h0000000B);
        tick();
        check("we0_no_write", rdata_a, 32'h0000000B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
